i2c_slave_ram_sequencer: RTL and testbench



---
 rtl/i2c_slave_ram_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_i2c_slave_ram_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ram_sequencer.sv
// i2c_slave_ram_sequencer
// Transaction sequencer between the I2C slave byte engine and the I2C RAM
// controller. Decodes the slave-address byte, decides ACK/NACK, loads a 5-bit
// register pointer, writes master data into Remote RAM and feeds master reads
// from Local RAM.
//
// Optional feature macro: I2C_SEQ_AUTOINC_EN
//   defined   - pointer increments after every WRITE byte and every served TxReq
//   undefined - pointer changes only in PTR state or on reset
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Stop         one-cycle bus condition pulses from the byte engine
//   RxByte, RxValid     received byte and its strobe
//   Ack                 registered ACK decision for the last received byte
//   TxReq, TxNack       engine requests next tx byte / master NACKed last byte
//   TxByte, TxValid     byte to transmit and its one-cycle update strobe
//   RemoteRAM_WADD/DIN/W  Remote RAM write port (registered, one-cycle strobe)
//   LocalRAM_RADD/DOUT  Local RAM read port (address = pointer, 1-cycle latency)
//   Busy                high whenever the sequencer is not IDLE
module i2c_slave_ram_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic [7:0] RxByte,
  input  logic       RxValid,
  output logic       Ack,
  input  logic       TxReq,
  input  logic       TxNack,
  output logic [7:0] TxByte,
  output logic       TxValid,
  output logic [4:0] RemoteRAM_WADD,
  output logic [7:0] RemoteRAM_DIN,
  output logic       RemoteRAM_W,
  output logic [4:0] LocalRAM_RADD,
  input  logic [7:0] LocalRAM_DOUT,
  output logic       Busy
);

  localparam int unsigned PTR_W  = 5;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PTR,
    S_WRITE,
    S_READ,
    S_IGNORE
  } state_t;

  state_t              state, state_d;
  logic [PTR_W-1:0]    ptr, ptr_d, ptr_inc;
  logic                ack_q, ack_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                tx_valid_q, tx_valid_d;
  logic                ram_w_q, ram_w_d;
  logic [PTR_W-1:0]    wadd_q, wadd_d;
  logic [BYTE_W-1:0]   din_q, din_d;
  logic                busy_q, busy_d;
  // TxReq seen last edge; data is taken from LocalRAM_DOUT on the next edge
  logic                tx_pend, tx_pend_d;

  // Pointer advance, or hold when auto-increment is not built in
`ifdef I2C_SEQ_AUTOINC_EN
  assign ptr_inc = ptr + PTR_W'(1);
`else
  assign ptr_inc = ptr;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      ack_q      <= 1'b0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      ram_w_q    <= 1'b0;
      wadd_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      tx_pend    <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      ack_q      <= ack_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      ram_w_q    <= ram_w_d;
      wadd_q     <= wadd_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      tx_pend    <= tx_pend_d;
    end
  end

  // Next-state and next-output logic; Start beats Stop, both beat data strobes
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    ack_d      = ack_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    ram_w_d    = 1'b0;
    wadd_d     = wadd_q;
    din_d      = din_q;
    tx_pend_d  = 1'b0;

    if (Start) begin
      state_d = S_ADDR;
      ack_d   = 1'b0;
    end else if (Stop) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
    end else begin
      // Second edge of a read: RAM data now reflects the pointer sampled with TxReq
      if (tx_pend) begin
        tx_byte_d  = LocalRAM_DOUT;
        tx_valid_d = 1'b1;
        ptr_d      = ptr_inc;
      end

      unique case (state)
        S_ADDR: begin
          if (RxValid) begin
            if (RxByte[7:1] == SLAVE_ADDR) begin
              ack_d   = 1'b1;
              state_d = RxByte[0] ? S_READ : S_PTR;
            end else begin
              ack_d   = 1'b0;
              state_d = S_IGNORE;
            end
          end
        end
        S_PTR: begin
          if (RxValid) begin
            ptr_d   = RxByte[PTR_W-1:0];
            ack_d   = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (RxValid) begin
            ram_w_d = 1'b1;
            wadd_d  = ptr;
            din_d   = RxByte;
            ack_d   = 1'b1;
            ptr_d   = ptr_inc;
          end
        end
        S_READ: begin
          if (TxNack) begin
            state_d = S_IGNORE;
          end else if (TxReq) begin
            tx_pend_d = 1'b1;
          end
          if (RxValid) ack_d = 1'b0;
        end
        default: begin
          // IDLE and IGNORE refuse every byte
          if (RxValid) ack_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign Ack            = ack_q;
  assign TxByte         = tx_byte_q;
  assign TxValid        = tx_valid_q;
  assign RemoteRAM_W    = ram_w_q;
  assign RemoteRAM_WADD = wadd_q;
  assign RemoteRAM_DIN  = din_q;
  assign LocalRAM_RADD  = ptr;
  assign Busy           = busy_q;

endmodule

// File: tb/tb_i2c_slave_ram_sequencer.sv
// Directed bench for i2c_slave_ram_sequencer. Expected Remote RAM writes and
// transmit bytes are queued when stimulus is driven and checked when the DUT
// strobes them. Follows I2C_SEQ_AUTOINC_EN the same way the design does.
module tb_i2c_slave_ram_sequencer;

`ifdef I2C_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       Start, Stop;
  logic [7:0] RxByte;
  logic       RxValid;
  logic       Ack;
  logic       TxReq, TxNack;
  logic [7:0] TxByte;
  logic       TxValid;
  logic [4:0] RemoteRAM_WADD;
  logic [7:0] RemoteRAM_DIN;
  logic       RemoteRAM_W;
  logic [4:0] LocalRAM_RADD;
  logic [7:0] LocalRAM_DOUT;
  logic       Busy;

  int unsigned vectors;
  int unsigned miscompares;

  logic [7:0]  lram [32];
  logic [7:0]  rram [32];
  logic [12:0] wq [$];   // {addr, data}
  logic [7:0]  tq [$];

  i2c_slave_ram_sequencer #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Stop(Stop),
    .RxByte(RxByte), .RxValid(RxValid), .Ack(Ack),
    .TxReq(TxReq), .TxNack(TxNack), .TxByte(TxByte), .TxValid(TxValid),
    .RemoteRAM_WADD(RemoteRAM_WADD), .RemoteRAM_DIN(RemoteRAM_DIN),
    .RemoteRAM_W(RemoteRAM_W), .LocalRAM_RADD(LocalRAM_RADD),
    .LocalRAM_DOUT(LocalRAM_DOUT), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local RAM with registered read
  always @(posedge clk) LocalRAM_DOUT <= lram[LocalRAM_RADD];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every DUT write strobe / transmit strobe
  task automatic mon();
    logic [12:0] w;
    if (RemoteRAM_W === 1'b1) begin
      rram[RemoteRAM_WADD] = RemoteRAM_DIN;
      chk("write_expected", 16'(wq.size() > 0), 16'd1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("remote_write", {3'b0, RemoteRAM_WADD, RemoteRAM_DIN}, {3'b0, w});
      end
    end
    if (TxValid === 1'b1) begin
      chk("txvalid_expected", 16'(tq.size() > 0), 16'd1);
      if (tq.size() > 0) chk("txbyte", 16'(TxByte), 16'(tq.pop_front()));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_start();
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("ack_after_start", 16'(Ack), 16'd0);
    chk("busy_after_start", 16'(Busy), 16'd1);
  endtask

  task automatic do_stop();
    Stop = 1'b1; cyc(); Stop = 1'b0;
    chk("busy_after_stop", 16'(Busy), 16'd0);
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
    RxByte = b; RxValid = 1'b1; cyc(); RxValid = 1'b0;
    chk(tag, 16'(Ack), 16'(exp_ack));
  endtask

  task automatic tx_req();
    TxReq = 1'b1; cyc(); TxReq = 1'b0;
    idle(3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},     16'(Ack), 16'd0);
    chk({tag, "_txbyte"},  16'(TxByte), 16'd0);
    chk({tag, "_txvalid"}, 16'(TxValid), 16'd0);
    chk({tag, "_ram_w"},   16'(RemoteRAM_W), 16'd0);
    chk({tag, "_wadd"},    16'(RemoteRAM_WADD), 16'd0);
    chk({tag, "_din"},     16'(RemoteRAM_DIN), 16'd0);
    chk({tag, "_radd"},    16'(LocalRAM_RADD), 16'd0);
    chk({tag, "_busy"},    16'(Busy), 16'd0);
  endtask

  initial begin
    logic [4:0] p;
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      lram[i] = 8'(i);
      rram[i] = 8'h00;
    end
    rst_n = 1'b0; Start = 1'b0; Stop = 1'b0; RxByte = 8'h00; RxValid = 1'b0;
    TxReq = 1'b0; TxNack = 1'b0;
    idle(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Write burst at pointer 5
    do_start();
    send("ack_addr_w", 8'h84, 1'b1);
    send("ack_ptr", 8'h05, 1'b1);
    wq.push_back({5'd5, 8'h41});
    send("ack_data0", 8'h41, 1'b1);
    wq.push_back({AUTOINC ? 5'd6 : 5'd5, 8'h42});
    send("ack_data1", 8'h42, 1'b1);
    do_stop();
    chk("ack_cleared_by_stop", 16'(Ack), 16'd0);
    chk("rram5_final", 16'(rram[5]), AUTOINC ? 16'h41 : 16'h42);
    idle(2);

    // Pointer wrap 31 -> 0
    do_start();
    send("ack_addr_wrap", 8'h84, 1'b1);
    send("ack_ptr_wrap", 8'h1F, 1'b1);
    wq.push_back({5'd31, 8'hAA});
    send("ack_wrap0", 8'hAA, 1'b1);
    wq.push_back({AUTOINC ? 5'd0 : 5'd31, 8'hBB});
    send("ack_wrap1", 8'hBB, 1'b1);
    do_stop();
    idle(2);

    // Register-read idiom: set pointer, repeated START, read three bytes
    do_start();
    send("ack_addr_rr", 8'h84, 1'b1);
    send("ack_ptr_rr", 8'h03, 1'b1);
    do_start();
    send("ack_addr_read", 8'h85, 1'b1);
    p = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tq.push_back(lram[p]);
      tx_req();
      if (AUTOINC) p = p + 5'd1;
    end
    chk("radd_after_reads", 16'(LocalRAM_RADD), 16'(p));
    TxNack = 1'b1; cyc(); TxNack = 1'b0;
    chk("busy_after_nack", 16'(Busy), 16'd1);
    tx_req();   // no TxValid allowed; mon flags any
    tx_req();
    send("ack_rx_in_ignore", 8'h11, 1'b0);
    // Start wins over simultaneous Stop
    Start = 1'b1; Stop = 1'b1; cyc(); Start = 1'b0; Stop = 1'b0;
    chk("start_beats_stop", 16'(Busy), 16'd1);
    do_stop();
    idle(2);

    // Address mismatch
    do_start();
    send("nack_addr", 8'h90, 1'b0);
    chk("busy_mismatch0", 16'(Busy), 16'd1);
    send("nack_b1", 8'h01, 1'b0);
    send("nack_b2", 8'h55, 1'b0);
    chk("busy_mismatch2", 16'(Busy), 16'd1);
    do_stop();
    idle(2);

    // Reset in the cycle a write strobe is live
    do_start();
    send("ack_addr_rst", 8'h84, 1'b1);
    send("ack_ptr_rst", 8'h07, 1'b1);
    wq.push_back({5'd7, 8'h66});
    send("ack_data_rst", 8'h66, 1'b1);
    chk("ram_w_before_rst", 16'(RemoteRAM_W), 16'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    do_start();
    send("ack_addr_after_rst", 8'h85, 1'b1);
    tq.push_back(lram[0]);
    tx_req();
    do_stop();
    idle(2);

    chk("write_queue_drained", 16'(wq.size()), 16'd0);
    chk("tx_queue_drained", 16'(tq.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
